// File: rtl/hash_pkg.sv
// Shared constants and types for the hash round datapath (sequencer and data selector).
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: round limit and counter width, block counter width, FSM state enum, seed constant.
package hash_pkg;

   localparam int LAST_ROUND = 33;   // final round index, rounds run 0..LAST_ROUND
   localparam int CNT_W      = 6;    // width of round counter and its delayed copy
   localparam int BLK_W      = 8;    // width of completed-block counter

   // Seed word selected by the round-data selector before feedback takes over.
   localparam logic [23:0] SEED = 24'hFE8901;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/round_seq_ctrl_if.sv
// Handshake and status bundle between the hash controller and the round sequencer.
// Latency: n/a (wiring only).
// Backpressure: hold stalls round advance; start is a request, busy/done report progress.
// master: drives start/hold, observes counter/counter_2d/busy/done/block_cnt. slave: the sequencer.
interface round_seq_ctrl_if #(
   parameter int CNT_W = hash_pkg::CNT_W,
   parameter int BLK_W = hash_pkg::BLK_W
);

   logic             start;
   logic             hold;
   logic [CNT_W-1:0] counter;
   logic [CNT_W-1:0] counter_2d;
   logic             busy;
   logic             done;
   logic [BLK_W-1:0] block_cnt;

   modport master (
      output start,
      output hold,
      input  counter,
      input  counter_2d,
      input  busy,
      input  done,
      input  block_cnt
   );

   modport slave (
      input  start,
      input  hold,
      output counter,
      output counter_2d,
      output busy,
      output done,
      output block_cnt
   );

endinterface

// File: rtl/delay2_reg.sv
// Generic W-bit two-stage delay line, shifting every clock.
// Latency: o_stage1 = i_d delayed 1 cycle, o_q = i_d delayed 2 cycles.
// Backpressure: none; always shifts.
// Ports: clk, reset (sync, active-high), i_d input word, o_stage1 first stage, o_q second stage.
module delay2_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_stage1,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_stage1 = r_s1;
   assign o_q      = r_s2;

endmodule

// File: rtl/round_seq_ctrl.sv
// Round sequencer: generates the round counter, a 2-cycle delayed copy, busy/done and a block count.
// Latency: round 0 appears the cycle after start is accepted; done fires 2 cycles after the final round.
// Backpressure: hold freezes the counter in RUN (except on the final round); start ignored mid-block.
// Ports: clk, reset (sync, active-high), bus (slave side: start, hold in; counter, counter_2d, busy, done, block_cnt out).
module round_seq_ctrl #(
   parameter int LAST_ROUND = hash_pkg::LAST_ROUND,
   parameter int CNT_W      = hash_pkg::CNT_W,
   parameter int BLK_W      = hash_pkg::BLK_W
) (
   input  logic                clk,
   input  logic                reset,
   round_seq_ctrl_if.slave     bus
);

   import hash_pkg::*;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_ROUND);

   state_t           r_state;
   logic             r_drain;        // 0 = first DRAIN cycle, 1 = second
   logic [CNT_W-1:0] r_counter;
   logic             r_busy;
   logic             r_done;
   logic [BLK_W-1:0] r_block_cnt;

   logic             w_last;
   logic [CNT_W-1:0] w_stage1;
   logic [CNT_W-1:0] w_cnt_2d;

   assign w_last = (r_counter == LAST_CNT);

   // Sequencer FSM. busy is registered alongside the state so it equals (state != IDLE).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_drain   <= 1'b0;
         r_counter <= '0;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_counter <= '0;
               if (bus.start) begin
                  // counter stays 0 so round 0 is visible in the first RUN cycle
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               if (w_last) begin
                  // final round always lasts one cycle regardless of hold,
                  // which guarantees a single done pulse per block
                  r_counter <= '0;
                  if (!bus.start) begin
                     r_state <= DRAIN;
                     r_drain <= 1'b0;
                  end
               end else if (!bus.hold) begin
                  r_counter <= r_counter + CNT_W'(1);
               end
            end
            DRAIN: begin
               // the delay line keeps shifting, so the pending done fires even on restart
               if (bus.start) begin
                  r_state   <= RUN;
                  r_counter <= '0;
               end else if (r_drain) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_counter <= '0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   delay2_reg #(
      .W (CNT_W)
   ) u_delay2 (
      .clk      (clk),
      .reset    (reset),
      .i_d      (r_counter),
      .o_stage1 (w_stage1),
      .o_q      (w_cnt_2d)
   );

   // done is registered from the first delay stage so it lines up exactly with
   // counter_2d == LAST_ROUND; block_cnt advances on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done      <= 1'b0;
         r_block_cnt <= '0;
      end else begin
         r_done <= (w_stage1 == LAST_CNT);
         if (w_stage1 == LAST_CNT) begin
            r_block_cnt <= r_block_cnt + BLK_W'(1);
         end
      end
   end

   assign bus.counter    = r_counter;
   assign bus.counter_2d = w_cnt_2d;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.block_cnt  = r_block_cnt;

endmodule

// File: tb/tb_round_seq_ctrl.sv
// Self-checking bench for round_seq_ctrl: scoreboard of expected done cycles and block counts.
module tb_round_seq_ctrl;

   import hash_pkg::*;

   typedef struct {
      int cyc;
      int blk;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   m_blk = 0;
   exp_t exp_q[$];

   round_seq_ctrl_if bus ();

   round_seq_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected done cycle for a block; block count wraps modulo 2^BLK_W
   task automatic push_exp(input int c);
      m_blk = (m_blk + 1) % (1 << BLK_W);
      exp_q.push_back('{c, m_blk});
   endtask

   task automatic wait_done(input int budget, output bit got);
      int n;
      got = 1'b0;
      n = 0;
      while (!got && n <= budget) begin
         if (bus.done === 1'b1) got = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b1;
      bus.hold = 1'b0;
      repeat (3) tick();
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL reset_counter: got %0d exp 0", bus.counter); end
      checks++; if (bus.counter_2d !== '0) begin errors++; $display("FAIL reset_counter_2d: got %0d exp 0", bus.counter_2d); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.done); end
      checks++; if (bus.block_cnt !== '0) begin errors++; $display("FAIL reset_block_cnt: got %0d exp 0", bus.block_cnt); end
      reset = 1'b0;
      bus.start = 1'b0;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b exp 0", bus.busy); end
   endtask

   task automatic test_abort();
      bit seen;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (20) tick();
      checks++; if (bus.counter !== CNT_W'(20)) begin errors++; $display("FAIL abort_pre_counter: got %0d exp 20", bus.counter); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL abort_counter: got %0d exp 0", bus.counter); end
      checks++; if (bus.counter_2d !== '0) begin errors++; $display("FAIL abort_counter_2d: got %0d exp 0", bus.counter_2d); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", bus.busy); end
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (bus.done !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b exp 0", seen); end
      checks++; if (bus.block_cnt !== BLK_W'(m_blk)) begin errors++; $display("FAIL abort_block_cnt: got %0d exp %0d", bus.block_cnt, m_blk); end
   endtask

   task automatic test_single_block();
      int   c;
      bit   got;
      exp_t e;
      c = cyc;
      push_exp(c + 36);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int r = 1; r <= 34; r++) begin
         checks++; if (bus.counter !== CNT_W'(r - 1)) begin errors++; $display("FAIL single_counter r=%0d: got %0d exp %0d", r, bus.counter, r - 1); end
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy r=%0d: got %b exp 1", r, bus.busy); end
         if (r >= 3) begin
            checks++; if (bus.counter_2d !== CNT_W'(r - 3)) begin errors++; $display("FAIL single_counter_2d r=%0d: got %0d exp %0d", r, bus.counter_2d, r - 3); end
         end
         tick();
      end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_drain_busy: got %b exp 1", bus.busy); end
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL single_drain_counter: got %0d exp 0", bus.counter); end
      wait_done(10, got);
      checks++; if (!got) begin errors++; $display("FAIL single_done_timeout: got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL single_done_cycle: got %0d exp %0d", cyc - c, e.cyc - c); end
      checks++; if (bus.counter_2d !== LAST_ROUND[CNT_W-1:0]) begin errors++; $display("FAIL single_done_2d: got %0d exp %0d", bus.counter_2d, LAST_ROUND); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b exp 0", bus.done); end
      checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL single_block_cnt: got %0d exp %0d", bus.block_cnt, e.blk); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b exp 0", bus.busy); end
   endtask

   // counter value r cycles after start when hold is high for cycles 11..15
   function automatic int hold_cnt(input int r);
      if (r <= 11) return r - 1;
      else if (r <= 16) return 10;
      else return r - 6;
   endfunction

   task automatic test_hold();
      int   c;
      bit   got;
      exp_t e;
      c = cyc;
      push_exp(c + 41);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int r = 1; r <= 39; r++) begin
         checks++; if (bus.counter !== CNT_W'(hold_cnt(r))) begin errors++; $display("FAIL hold_counter r=%0d: got %0d exp %0d", r, bus.counter, hold_cnt(r)); end
         if (r >= 3) begin
            checks++; if (bus.counter_2d !== CNT_W'(hold_cnt(r - 2))) begin errors++; $display("FAIL hold_counter_2d r=%0d: got %0d exp %0d", r, bus.counter_2d, hold_cnt(r - 2)); end
         end
         bus.hold = ((r >= 11) && (r <= 15)) || (r == 39);
         tick();
      end
      bus.hold = 1'b0;
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL hold_final_ignored: got %0d exp 0", bus.counter); end
      wait_done(10, got);
      checks++; if (!got) begin errors++; $display("FAIL hold_done_timeout: got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL hold_done_cycle: got %0d exp %0d", cyc - c, e.cyc - c); end
      tick();
      checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL hold_block_cnt: got %0d exp %0d", bus.block_cnt, e.blk); end
   endtask

   task automatic test_back_to_back();
      int   c;
      bit   got;
      exp_t e;
      c = cyc;
      push_exp(c + 36);
      push_exp(c + 70);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (33) tick();
      checks++; if (bus.counter !== LAST_ROUND[CNT_W-1:0]) begin errors++; $display("FAIL b2b_last: got %0d exp %0d", bus.counter, LAST_ROUND); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL b2b_restart_counter: got %0d exp 0", bus.counter); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b exp 1", bus.busy); end
      for (int k = 0; k < 2; k++) begin
         wait_done(40, got);
         checks++; if (!got) begin errors++; $display("FAIL b2b_done_timeout k=%0d: got 0 exp 1", k); end
         e = exp_q.pop_front();
         checks++; if (cyc != e.cyc) begin errors++; $display("FAIL b2b_done_cycle k=%0d: got %0d exp %0d", k, cyc - c, e.cyc - c); end
         tick();
         checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL b2b_block_cnt k=%0d: got %0d exp %0d", k, bus.block_cnt, e.blk); end
         checks++; if (bus.busy !== (k == 0)) begin errors++; $display("FAIL b2b_busy_after k=%0d: got %b exp %b", k, bus.busy, k == 0); end
      end
   endtask

   task automatic test_drain_restart();
      int   c;
      bit   got;
      exp_t e;
      c = cyc;
      push_exp(c + 36);
      push_exp(c + 71);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (34) tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %b exp 1", bus.busy); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL drain_pending_done: got %b exp 1", bus.done); end
      e = exp_q.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL drain_done_cycle: got %0d exp %0d", cyc - c, e.cyc - c); end
      checks++; if (bus.counter !== '0) begin errors++; $display("FAIL drain_restart_counter: got %0d exp 0", bus.counter); end
      tick();
      checks++; if (bus.counter !== CNT_W'(1)) begin errors++; $display("FAIL drain_restart_run: got %0d exp 1", bus.counter); end
      checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL drain_block_cnt: got %0d exp %0d", bus.block_cnt, e.blk); end
      wait_done(40, got);
      checks++; if (!got) begin errors++; $display("FAIL drain_done2_timeout: got 0 exp 1"); end
      e = exp_q.pop_front();
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL drain_done2_cycle: got %0d exp %0d", cyc - c, e.cyc - c); end
      tick();
      checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL drain_block_cnt2: got %0d exp %0d", bus.block_cnt, e.blk); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drain_idle_busy: got %b exp 0", bus.busy); end
   endtask

   task automatic test_wrap();
      int   c;
      bit   got;
      exp_t e;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_blk = 0;
      exp_q.delete();
      c = cyc;
      bus.start = 1'b1;
      for (int k = 1; k <= 256; k++) push_exp(c + 34 * k + 2);
      for (int k = 1; k <= 256; k++) begin
         wait_done(40, got);
         if (!got) begin
            checks++; errors++;
            $display("FAIL wrap_done_timeout k=%0d: got 0 exp 1", k);
            break;
         end
         e = exp_q.pop_front();
         checks++; if (cyc != e.cyc) begin errors++; $display("FAIL wrap_done_cycle k=%0d: got %0d exp %0d", k, cyc - c, e.cyc - c); end
         tick();
         checks++; if (bus.block_cnt !== BLK_W'(e.blk)) begin errors++; $display("FAIL wrap_block_cnt k=%0d: got %0d exp %0d", k, bus.block_cnt, e.blk); end
         if (k == 255) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      checks++; if (bus.block_cnt !== '0) begin errors++; $display("FAIL wrap_zero: got %0d exp 0", bus.block_cnt); end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_single_block();
      test_hold();
      test_back_to_back();
      test_drain_restart();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
